// File: rtl/piso_16bit_pkg.sv
// Shared types and sizing for the 16-bit parallel-in/serial-out word streamer
// and its serial-in/parallel-out receiver counterpart.
package piso_16bit_pkg;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CNT_W = $clog2(DEPTH);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEPTH - 1);

  typedef logic [WIDTH-1:0] word_t;

  typedef enum logic {
    StIdle,
    StShift
  } state_e;

endpackage

// File: rtl/piso_16bit_if.sv
// Load and valid/ready output handshake bundle for piso_16bit.
interface piso_16bit_if;
  import piso_16bit_pkg::*;

  logic  load;
  word_t d0, d1, d2, d3, d4, d5, d6, d7;
  logic  load_rdy;
  word_t q;
  logic  q_valid;
  logic  q_ready;
  logic  q_last;
  logic  busy;

  modport master (
    output load, d0, d1, d2, d3, d4, d5, d6, d7, q_ready,
    input  load_rdy, q, q_valid, q_last, busy
  );

  modport slave (
    input  load, d0, d1, d2, d3, d4, d5, d6, d7, q_ready,
    output load_rdy, q, q_valid, q_last, busy
  );

endinterface

// File: rtl/piso_word_stage.sv
// One word of the streamer bank: register with parallel-load vs shift-in mux,
// enable and synchronous active-low reset.
module piso_word_stage #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_d_i,
  input  logic [Width-1:0] shift_d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] q_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      q_q <= '0;
    end else if (en_i) begin
      q_q <= load_i ? load_d_i : shift_d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/piso_16bit.sv
// Parallel-in/serial-out word streamer: captures d0..d7 in one load and emits
// them d0 first over a valid/ready port, with bubble-free back-to-back loads.
module piso_16bit
  import piso_16bit_pkg::*;
(
  input logic         clk,
  input logic         rst,
  piso_16bit_if.slave bus
);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  word_t            w        [DEPTH];
  word_t            d_par    [DEPTH];
  word_t            shift_in [DEPTH];
  logic             q_valid;
  logic             q_last;
  logic             xfer;
  logic             load_rdy;
  logic             accept;

  assign q_valid  = (state_q == StShift);
  assign q_last   = q_valid && (cnt_q == LAST_CNT);
  assign xfer     = q_valid && bus.q_ready;
  // Final transfer frees the bank in the same cycle, so a new load can land without a gap.
  assign load_rdy = (state_q == StIdle) || (xfer && q_last);
  assign accept   = bus.load && load_rdy;

  always_comb begin
    d_par[0] = bus.d0;
    d_par[1] = bus.d1;
    d_par[2] = bus.d2;
    d_par[3] = bus.d3;
    d_par[4] = bus.d4;
    d_par[5] = bus.d5;
    d_par[6] = bus.d6;
    d_par[7] = bus.d7;
  end

  always_comb begin
    for (int i = 0; i < DEPTH - 1; i++) begin
      shift_in[i] = w[i+1];
    end
    shift_in[DEPTH-1] = '0;
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    piso_word_stage #(
      .Width (WIDTH)
    ) u_stage (
      .clk_i     (clk),
      .rst_ni    (rst),
      .en_i      (accept || xfer),
      .load_i    (accept),
      .load_d_i  (d_par[i]),
      .shift_d_i (shift_in[i]),
      .q_o       (w[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else if (accept) begin
      state_q <= StShift;
      cnt_q   <= '0;
    end else if (xfer) begin
      if (q_last) begin
        state_q <= StIdle;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.q        = w[0];
  assign bus.q_valid  = q_valid;
  assign bus.q_last   = q_last;
  assign bus.load_rdy = load_rdy;
  assign bus.busy     = (state_q == StShift);

endmodule

// File: tb/tb_piso_16bit.sv
// Scenario bench for piso_16bit with an expected-word queue scoreboard.
module tb_piso_16bit;
  import piso_16bit_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;

  piso_16bit_if bus ();

  piso_16bit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Each entry is {last, word}.
  logic [WIDTH:0] exp_q [$];
  logic [WIDTH:0] exp;

  task automatic set_d(input logic [15:0] base, input logic [15:0] inc);
    bus.d0 = base;
    bus.d1 = base + inc;
    bus.d2 = base + 16'(2 * inc);
    bus.d3 = base + 16'(3 * inc);
    bus.d4 = base + 16'(4 * inc);
    bus.d5 = base + 16'(5 * inc);
    bus.d6 = base + 16'(6 * inc);
    bus.d7 = base + 16'(7 * inc);
  endtask

  task automatic push_stream(input logic [15:0] base);
    logic l;
    for (int i = 0; i < DEPTH; i++) begin
      l = (i == DEPTH - 1);
      exp_q.push_back({l, base + 16'(i)});
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.load = 1'b0;
    bus.q_ready = 1'b0;
    set_d(16'h0, 16'h0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    total++;
    if ({bus.q_valid, bus.q_last, bus.busy, bus.load_rdy, bus.q} !== {4'b0001, 16'h0}) begin
      bad++;
      $display("FAIL reset_state: got valid=%b last=%b busy=%b rdy=%b q=%h want 0 0 0 1 0000",
               bus.q_valid, bus.q_last, bus.busy, bus.load_rdy, bus.q);
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      total++;
      if ({bus.q_valid, bus.q_last, bus.busy, bus.load_rdy, bus.q} !== {4'b0001, 16'h0}) begin
        bad++;
        $display("FAIL idle_hold c=%0d: got valid=%b last=%b busy=%b rdy=%b q=%h want 0 0 0 1 0000",
                 c, bus.q_valid, bus.q_last, bus.busy, bus.load_rdy, bus.q);
      end
    end
  endtask

  task automatic test_basic();
    @(posedge clk);
    #1;
    set_d(16'h1000, 16'h1);
    bus.load = 1'b1;
    bus.q_ready = 1'b1;
    @(negedge clk);
    total++;
    if (bus.load_rdy !== 1'b1) begin
      bad++;
      $display("FAIL basic_load_rdy: got %b want 1", bus.load_rdy);
    end
    push_stream(16'h1000);
    @(posedge clk);
    #1 bus.load = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      @(negedge clk);
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL basic_underflow k=%0d: got empty queue want entry", k);
      end else begin
        exp = exp_q.pop_front();
        if ({bus.q_valid, bus.busy, bus.q_last, bus.q} !== {2'b11, exp}) begin
          bad++;
          $display("FAIL basic_word k=%0d: got valid=%b busy=%b last=%b q=%h want 1 1 %b %h",
                   k, bus.q_valid, bus.busy, bus.q_last, bus.q, exp[WIDTH], exp[WIDTH-1:0]);
        end
      end
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    total++;
    if ({bus.q_valid, bus.q_last, bus.busy, bus.load_rdy} !== 4'b0001) begin
      bad++;
      $display("FAIL basic_end: got valid=%b last=%b busy=%b rdy=%b want 0 0 0 1",
               bus.q_valid, bus.q_last, bus.busy, bus.load_rdy);
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    int xfers;
    @(posedge clk);
    #1;
    set_d(16'h1000, 16'h1);
    bus.load = 1'b1;
    bus.q_ready = 1'b1;
    @(negedge clk);
    total++;
    if (bus.load_rdy !== 1'b1) begin
      bad++;
      $display("FAIL bp_load_rdy: got %b want 1", bus.load_rdy);
    end
    push_stream(16'h1000);
    @(posedge clk);
    #1 bus.load = 1'b0;
    cyc = 0;
    xfers = 0;
    while (xfers < DEPTH && cyc < 40) begin
      bus.q_ready = (cyc % 3 == 0);
      @(negedge clk);
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL bp_underflow cyc=%0d: got empty queue want entry", cyc);
      end else if ({bus.q_valid, bus.q_last, bus.q} !== {1'b1, exp_q[0]}) begin
        bad++;
        $display("FAIL bp_word cyc=%0d: got valid=%b last=%b q=%h want 1 %b %h",
                 cyc, bus.q_valid, bus.q_last, bus.q, exp_q[0][WIDTH], exp_q[0][WIDTH-1:0]);
      end
      if (bus.q_ready && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        xfers++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.q_ready = 1'b1;
    @(negedge clk);
    total++;
    if (bus.q_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_end: got valid=%b want 0 after 8 transfers", bus.q_valid);
    end
  endtask

  task automatic test_ignored_load();
    @(posedge clk);
    #1;
    set_d(16'h1000, 16'h1);
    bus.load = 1'b1;
    bus.q_ready = 1'b1;
    @(negedge clk);
    push_stream(16'h1000);
    @(posedge clk);
    #1;
    for (int k = 0; k < DEPTH; k++) begin
      if (k == 3) begin
        bus.load = 1'b1;
        set_d(16'hFFFF, 16'h0);
      end else begin
        bus.load = 1'b0;
      end
      @(negedge clk);
      if (k == 3) begin
        total++;
        if (bus.load_rdy !== 1'b0) begin
          bad++;
          $display("FAIL ign_load_rdy: got %b want 0", bus.load_rdy);
        end
      end
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL ign_underflow k=%0d: got empty queue want entry", k);
      end else begin
        exp = exp_q.pop_front();
        if ({bus.q_valid, bus.q_last, bus.q} !== {1'b1, exp}) begin
          bad++;
          $display("FAIL ign_word k=%0d: got valid=%b last=%b q=%h want 1 %b %h",
                   k, bus.q_valid, bus.q_last, bus.q, exp[WIDTH], exp[WIDTH-1:0]);
        end
      end
      @(posedge clk);
      #1;
    end
    bus.load = 1'b0;
    @(negedge clk);
    total++;
    if ({bus.q_valid, bus.q} !== {1'b0, 16'h0}) begin
      bad++;
      $display("FAIL ign_end: got valid=%b q=%h want 0 0000", bus.q_valid, bus.q);
    end
  endtask

  task automatic test_back_to_back();
    @(posedge clk);
    #1;
    set_d(16'h1000, 16'h1);
    bus.load = 1'b1;
    bus.q_ready = 1'b1;
    @(negedge clk);
    push_stream(16'h1000);
    @(posedge clk);
    #1;
    for (int k = 0; k < 2 * DEPTH; k++) begin
      if (k == DEPTH - 1) begin
        bus.load = 1'b1;
        set_d(16'h2000, 16'h1);
      end else begin
        bus.load = 1'b0;
      end
      @(negedge clk);
      if (k == DEPTH - 1) begin
        total++;
        if (bus.load_rdy !== 1'b1) begin
          bad++;
          $display("FAIL b2b_load_rdy: got %b want 1", bus.load_rdy);
        end
      end
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL b2b_underflow k=%0d: got empty queue want entry", k);
      end else begin
        exp = exp_q.pop_front();
        if ({bus.q_valid, bus.q_last, bus.q} !== {1'b1, exp}) begin
          bad++;
          $display("FAIL b2b_word k=%0d: got valid=%b last=%b q=%h want 1 %b %h",
                   k, bus.q_valid, bus.q_last, bus.q, exp[WIDTH], exp[WIDTH-1:0]);
        end
      end
      if (k == DEPTH - 1) push_stream(16'h2000);
      @(posedge clk);
      #1;
    end
    bus.load = 1'b0;
    @(negedge clk);
    total++;
    if (bus.q_valid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_end: got valid=%b want 0", bus.q_valid);
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk);
    #1;
    set_d(16'h1000, 16'h1);
    bus.load = 1'b1;
    bus.q_ready = 1'b1;
    @(negedge clk);
    push_stream(16'h1000);
    @(posedge clk);
    #1 bus.load = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++;
      exp = exp_q.pop_front();
      if ({bus.q_valid, bus.q_last, bus.q} !== {1'b1, exp}) begin
        bad++;
        $display("FAIL mid_word k=%0d: got valid=%b last=%b q=%h want 1 %b %h",
                 k, bus.q_valid, bus.q_last, bus.q, exp[WIDTH], exp[WIDTH-1:0]);
      end
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    total++;
    if ({bus.q_valid, bus.q_last, bus.busy, bus.load_rdy, bus.q} !== {4'b0001, 16'h0}) begin
      bad++;
      $display("FAIL mid_reset: got valid=%b last=%b busy=%b rdy=%b q=%h want 0 0 0 1 0000",
               bus.q_valid, bus.q_last, bus.busy, bus.load_rdy, bus.q);
    end
    @(posedge clk);
    #1;
    set_d(16'h3000, 16'h1);
    bus.load = 1'b1;
    @(negedge clk);
    push_stream(16'h3000);
    @(posedge clk);
    #1 bus.load = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      @(negedge clk);
      total++;
      exp = exp_q.pop_front();
      if ({bus.q_valid, bus.q_last, bus.q} !== {1'b1, exp}) begin
        bad++;
        $display("FAIL restart_word k=%0d: got valid=%b last=%b q=%h want 1 %b %h",
                 k, bus.q_valid, bus.q_last, bus.q, exp[WIDTH], exp[WIDTH-1:0]);
      end
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    total++;
    if (bus.q_valid !== 1'b0) begin
      bad++;
      $display("FAIL restart_end: got valid=%b want 0", bus.q_valid);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_ignored_load();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/piso_16bit.md
Name: piso_16bit

Overview:
- Parallel-in/serial-out word streamer. Captures eight 16-bit words in one load cycle, then emits them one word per accepted transfer on a valid/ready output.
- It is the transmit-side counterpart of the 8-stage serial-in/parallel-out word register bank.
- Emission order is d0 first, d7 last. A serial-in/parallel-out bank fed from this block therefore reproduces d7..d0 on its parallel outputs after 8 shifts.

Parameters:
- WIDTH, 16, bits per word.
- DEPTH, 8, words per load; counter width is clog2(DEPTH) = 3.

Ports:
- clk  input  1  rising-edge clock, single clock domain.
- rst  input  1  synchronous, active-low reset (sampled on clk rising edge; 0 = reset).
- load  input  1  request to capture d7..d0. Accepted only when load_rdy = 1.
- d7..d0  input  WIDTH each  parallel words; d0 is emitted first.
- load_rdy  output  1  block can accept a load this cycle.
- q  output  WIDTH  current output word.
- q_valid  output  1  q holds a valid word.
- q_ready  input  1  downstream accepts q this cycle.
- q_last  output  1  q is the final (8th) word of the current load.
- busy  output  1  high while in SHIFT.

Behaviour:
- States:
  - IDLE: q_valid = 0.
  - SHIFT: q_valid = 1.
- Internal state: word bank w[0..7], 3-bit index cnt.
- Reset (rst = 0 at clk edge), from any state:
  - state goes to IDLE; w[*] = 0; cnt = 0.
  - q = 0, q_valid = 0, q_last = 0, busy = 0, load_rdy = 1.
  - Reset mid-stream aborts the stream and discards the remaining words. No partial q_last is issued.
- Load acceptance: load && load_rdy at an edge.
  - w[i] <= d_i, cnt <= 0, state <= SHIFT.
  - Next cycle: q = d0, q_valid = 1 (1-cycle latency).
- A load request while load_rdy = 0 is ignored, with no side effects. Inputs are not held internally.
- Transfer: q_valid && q_ready at an edge.
  - Bank shifts toward head: w[i] <= w[i+1], w[7] <= 0.
  - cnt <= cnt + 1.
- q = w[0], driven directly from a register (no combinational path from inputs to q).
- q_last = q_valid && (cnt == 7).
- Transfer with q_last set: state <= IDLE, cnt <= 0, q_valid falls next cycle. Exactly 8 transfers occur per load.
- Back-to-back loads:
  - load_rdy = (state == IDLE) || (q_valid && q_ready && q_last). This is a combinational path from q_ready to load_rdy by design.
  - A load accepted in the same cycle as the final transfer takes priority. The new d0 appears next cycle with q_valid still 1, so there is no bubble.
- Backpressure: while q_valid && !q_ready, q, q_last, cnt and w[*] hold stable. valid must not drop without a transfer.
- q after the stream ends holds the shifted-in 0. Its value is don't-care while q_valid = 0, but is 0 after reset.
- cnt never wraps past 7 inside a stream; it is reset to 0 on exit.

Decomposition:
- Shared package:
  - WIDTH = 16, DEPTH = 8, CNT_W = 3.
  - state enum {IDLE, SHIFT}, reused by the matching receiver's control.
- One natural sub-module: piso_word_stage.
  - A WIDTH-bit register with sync active-low reset and a 2:1 input mux (parallel load vs shift-from-neighbour) plus enable.
  - Eight instances are chained w[7] -> w[0]; the top level holds the FSM, counter and handshake.

Test Plan:
- Reset then idle: hold rst = 0 for 3 cycles, release -> q_valid = 0, q = 0, load_rdy = 1, busy = 0; load = 0 for 5 cycles keeps all outputs unchanged.
- Basic stream: load d0..d7 = 0x1000..0x1007 with q_ready = 1 constantly -> q = 0x1000,0x1001,...,0x1007 on 8 consecutive cycles starting 1 cycle after load; q_last only on 0x1007; q_valid = 0 on the following cycle.
- Backpressure: same load, q_ready toggles 1,0,0,1,... -> each word is held stable while q_ready = 0; output sequence is identical; exactly 8 transfers occur.
- Ignored load: assert load with d = 0xFFFF during transfer 3 of a stream -> load_rdy = 0, stream continues 0x1003..0x1007 unaffected.
- Back-to-back: assert a second load (0x2000..0x2007) in the cycle of the 0x1007 transfer -> load_rdy = 1 that cycle; the next cycle shows q = 0x2000 with q_valid = 1, no gap.
- Reset mid-stream: rst = 0 after 4 transfers -> next cycle q_valid = 0, q = 0, load_rdy = 1; a fresh load then restarts from its own d0.
